// File: rtl/rs_pkg.sv
// Shared Reed-Solomon constants for the C1 path: GF(256) field polynomial,
// generator coefficients for roots alpha^0..alpha^3, and the encoder state type.
package rs_pkg;
  localparam logic [8:0]  GF_POLY = 9'h11D;
  localparam logic [7:0]  G3      = 8'h0F;
  localparam logic [7:0]  G2      = 8'h36;
  localparam logic [7:0]  G1      = 8'h78;
  localparam logic [7:0]  G0      = 8'h40;
  localparam int unsigned RS_NPAR = 4;

  typedef enum logic {
    DATA = 1'b0,
    PAR  = 1'b1
  } state_t;
endpackage

// File: rtl/gf256_mult.sv
// GF(256) multiplier reduced by GF_POLY; with b tied to a constant it
// collapses to an XOR network.
module gf256_mult
  import rs_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] p
);

  logic [7:0] acc;
  logic [7:0] sh;

  always_comb begin
    acc = '0;
    sh  = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? GF_POLY[7:0] : 8'h00);
    end
    p = acc;
  end

endmodule

// File: rtl/rs_c1_encoder.sv
// Systematic RS(N_DATA+4, N_DATA) encoder: echoes message bytes, then emits
// the four LFSR remainder bytes, over a valid/ready stream.
module rs_c1_encoder
  import rs_pkg::*;
#(
  parameter int unsigned N_DATA = 28
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_valid,
  input  logic [7:0] i_data,
  output logic       o_ready,
  output logic       o_valid,
  output logic [7:0] o_data,
  output logic       o_last,
  input  logic       i_ready
);

  localparam int unsigned CW = (N_DATA > 1) ? $clog2(N_DATA) : 1;
  localparam logic [CW-1:0] LAST_BYTE = CW'(N_DATA - 1);
  localparam logic [1:0]    LAST_PAR  = 2'(RS_NPAR - 1);

  state_t        state;
  logic [CW-1:0] byte_cnt;
  logic [1:0]    par_cnt;
  logic [7:0]    r3, r2, r1, r0;
  logic [7:0]    fb;
  logic [7:0]    m3, m2, m1, m0;
  logic          load_ok;
  logic          accept;
  logic          par_load;

  assign fb       = i_data ^ r3;
  assign load_ok  = ~o_valid | i_ready;
  assign o_ready  = (state == DATA) & load_ok;
  assign accept   = o_ready & i_valid;
  assign par_load = (state == PAR) & load_ok;

  gf256_mult u_mul3 (.a(fb), .b(G3), .p(m3));
  gf256_mult u_mul2 (.a(fb), .b(G2), .p(m2));
  gf256_mult u_mul1 (.a(fb), .b(G1), .p(m1));
  gf256_mult u_mul0 (.a(fb), .b(G0), .p(m0));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= DATA;
      byte_cnt <= '0;
      par_cnt  <= '0;
      r3       <= '0;
      r2       <= '0;
      r1       <= '0;
      r0       <= '0;
      o_valid  <= 1'b0;
      o_data   <= '0;
      o_last   <= 1'b0;
    end else if (accept) begin
      o_data  <= i_data;
      o_valid <= 1'b1;
      o_last  <= 1'b0;
      r3      <= r2 ^ m3;
      r2      <= r1 ^ m2;
      r1      <= r0 ^ m1;
      r0      <= m0;
      if (byte_cnt == LAST_BYTE) begin
        state    <= PAR;
        par_cnt  <= '0;
        byte_cnt <= '0;
      end else begin
        byte_cnt <= byte_cnt + 1'b1;
      end
    end else if (par_load) begin
      o_data  <= r3;
      o_valid <= 1'b1;
      par_cnt <= par_cnt + 2'd1;
      // Final parity byte also clears the remainder so the next codeword starts clean.
      if (par_cnt == LAST_PAR) begin
        o_last   <= 1'b1;
        state    <= DATA;
        byte_cnt <= '0;
        r3       <= '0;
        r2       <= '0;
        r1       <= '0;
        r0       <= '0;
      end else begin
        o_last <= 1'b0;
        r3     <= r2;
        r2     <= r1;
        r1     <= r0;
        r0     <= '0;
      end
    end else if (o_valid & i_ready) begin
      o_valid <= 1'b0;
      o_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rs_c1_encoder.sv
// Scoreboard bench for rs_c1_encoder: a polynomial-division model predicts each
// codeword, a monitor pops and compares every transferred byte and checks syndromes.
module tb_rs_c1_encoder;
  localparam int unsigned N = 28;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } item_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vin = 1'b0;
  logic [7:0] din = 8'h00;
  logic       oready, ovalid, olast;
  logic [7:0] dout;
  logic       ready = 1'b1;

  logic       v1 = 1'b0;
  logic [7:0] d1 = 8'h00;
  logic       or1, ov1, ol1;
  logic [7:0] od1;
  logic       ready1 = 1'b1;

  logic       rnd_mode = 1'b0;
  logic       cnt_en = 1'b0;
  int         low_cnt = 0;

  int n_cmp = 0;
  int n_bad = 0;

  item_t      q[$];
  item_t      q1[$];
  logic [7:0] cw[$];

  logic [7:0] gexp[512];
  int         glog[256];

  rs_c1_encoder #(.N_DATA(N)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(vin), .i_data(din), .o_ready(oready),
    .o_valid(ovalid), .o_data(dout), .o_last(olast), .i_ready(ready)
  );

  rs_c1_encoder #(.N_DATA(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_valid(v1), .i_data(d1), .o_ready(or1),
    .o_valid(ov1), .o_data(od1), .o_last(ol1), .i_ready(ready1)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    if (a == 8'h00 || b == 8'h00) return 8'h00;
    return gexp[glog[a] + glog[b]];
  endfunction

  task automatic build_tables();
    logic [7:0] x;
    x = 8'h01;
    for (int i = 0; i < 255; i++) begin
      gexp[i] = x;
      glog[x] = i;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
    end
    for (int i = 255; i < 512; i++) gexp[i] = gexp[i-255];
  endtask

  // Remainder of m(x)*x^4 divided by g(x), by long division.
  task automatic push_codeword(input logic [7:0] msg[$]);
    logic [7:0] g[5];
    logic [7:0] rem[$];
    logic [7:0] c;
    item_t      it;
    g = '{8'h01, 8'h0F, 8'h36, 8'h78, 8'h40};
    rem = msg;
    for (int k = 0; k < 4; k++) rem.push_back(8'h00);
    for (int i = 0; i < msg.size(); i++) begin
      c = rem[i];
      for (int k = 1; k < 5; k++) rem[i+k] = rem[i+k] ^ gmul(c, g[k]);
    end
    foreach (msg[i]) begin
      it.d = msg[i]; it.l = 1'b0; q.push_back(it);
    end
    for (int k = 0; k < 4; k++) begin
      it.d = rem[msg.size()+k]; it.l = (k == 3); q.push_back(it);
    end
  endtask

  task automatic send_byte(input logic [7:0] d);
    logic acc;
    int   t;
    vin = 1'b1;
    din = d;
    t = 0;
    do begin
      @(negedge clk);
      acc = oready;
      @(posedge clk);
      #1;
      t++;
    end while (!acc && t < 1000);
    if (!acc) chk("accept_timeout", 32'(acc), 32'd1);
    vin = 1'b0;
  endtask

  task automatic send_msg(input logic [7:0] msg[$], input bit gaps);
    foreach (msg[i]) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      send_byte(msg[i]);
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((q.size() != 0 || q1.size() != 0) && t < 2000) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 2000) chk("drain_timeout", 32'(q.size()), 32'd0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge clk);
    chk({tag, "_valid"}, 32'(ovalid), 32'd0);
    chk({tag, "_data"}, 32'(dout), 32'd0);
    chk({tag, "_last"}, 32'(olast), 32'd0);
    chk({tag, "_ready"}, 32'(oready), 32'd1);
  endtask

  always @(posedge clk) begin
    #1;
    ready = rnd_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  always @(negedge clk) if (cnt_en && !oready) low_cnt++;

  always @(negedge clk) begin
    item_t      it;
    logic [7:0] s;
    if (rst) begin
      cw.delete();
    end else if (ovalid && ready) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_byte: got 0x%0h, expected no output", dout);
      end else begin
        it = q.pop_front();
        chk("data", 32'(dout), 32'(it.d));
        chk("last", 32'(olast), 32'(it.l));
        cw.push_back(dout);
        if (olast) begin
          chk("cw_len", 32'(cw.size()), 32'(N + 4));
          for (int j = 0; j < 4; j++) begin
            s = 8'h00;
            foreach (cw[k]) s = gmul(s, gexp[j]) ^ cw[k];
            chk("syndrome", 32'(s), 32'd0);
          end
          cw.delete();
        end
      end
    end
  end

  always @(negedge clk) begin
    item_t it;
    if (!rst && ov1 && ready1) begin
      if (q1.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL n1_unexpected: got 0x%0h, expected no output", od1);
      end else begin
        it = q1.pop_front();
        chk("n1_data", 32'(od1), 32'(it.d));
        chk("n1_last", 32'(ol1), 32'(it.l));
      end
    end
  end

  initial begin
    logic [7:0] msg[$];
    item_t      it;
    build_tables();

    repeat (2) @(posedge clk);
    check_reset_outputs("rst_init");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // All-zero message, full throughput, count o_ready low cycles.
    msg.delete();
    for (int i = 0; i < N; i++) msg.push_back(8'h00);
    push_codeword(msg);
    cnt_en = 1'b1;
    send_msg(msg, 1'b0);
    wait_drain();
    cnt_en = 1'b0;
    chk("ready_low_cycles", 32'(low_cnt), 32'd4);

    // Single trailing 1: parity equals the generator coefficients.
    msg.delete();
    for (int i = 0; i < N - 1; i++) msg.push_back(8'h00);
    msg.push_back(8'h01);
    foreach (msg[i]) begin
      it.d = msg[i]; it.l = 1'b0; q.push_back(it);
    end
    it = '{d: 8'h0F, l: 1'b0}; q.push_back(it);
    it = '{d: 8'h36, l: 1'b0}; q.push_back(it);
    it = '{d: 8'h78, l: 1'b0}; q.push_back(it);
    it = '{d: 8'h40, l: 1'b1}; q.push_back(it);
    send_msg(msg, 1'b0);
    wait_drain();

    // Random messages, back to back with downstream always ready.
    for (int c = 0; c < 100; c++) begin
      msg.delete();
      for (int i = 0; i < N; i++) msg.push_back(8'($urandom));
      push_codeword(msg);
      send_msg(msg, 1'b0);
    end
    wait_drain();

    // Random messages with random upstream gaps and downstream backpressure.
    rnd_mode = 1'b1;
    for (int c = 0; c < 100; c++) begin
      msg.delete();
      for (int i = 0; i < N; i++) msg.push_back(8'($urandom));
      push_codeword(msg);
      send_msg(msg, 1'b1);
    end
    wait_drain();
    rnd_mode = 1'b0;
    @(posedge clk);
    #1;

    // Partial codeword then reset, then a clean codeword.
    msg.delete();
    for (int i = 0; i < 11; i++) msg.push_back(8'($urandom));
    foreach (msg[i]) begin
      it.d = msg[i]; it.l = 1'b0; q.push_back(it);
    end
    send_msg(msg, 1'b0);
    wait_drain();
    rst = 1'b1;
    check_reset_outputs("rst_mid");
    @(posedge clk);
    #1;
    rst = 1'b0;
    msg.delete();
    for (int i = 0; i < N; i++) msg.push_back(8'($urandom));
    push_codeword(msg);
    send_msg(msg, 1'b1);
    wait_drain();

    // One-byte message instance.
    it = '{d: 8'h01, l: 1'b0}; q1.push_back(it);
    it = '{d: 8'h0F, l: 1'b0}; q1.push_back(it);
    it = '{d: 8'h36, l: 1'b0}; q1.push_back(it);
    it = '{d: 8'h78, l: 1'b0}; q1.push_back(it);
    it = '{d: 8'h40, l: 1'b1}; q1.push_back(it);
    v1 = 1'b1;
    d1 = 8'h01;
    @(negedge clk);
    chk("n1_ready", 32'(or1), 32'd1);
    @(posedge clk);
    #1;
    v1 = 1'b0;
    wait_drain();
    chk("queue_empty", 32'(q.size() + q1.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
